// File: rtl/fetch_ibuf_stage.sv
// Instruction fetch stage for an sram-like req/addr_ok/data_ok bus.
// Keeps up to MAX_OUTSTANDING fetches in flight, tags each with its pc,
// and queues returned words in an in-order instruction buffer for decode.
// A redirect clears the buffer and drops every response still in flight,
// including a request that was already raised but not yet accepted.
module fetch_ibuf_stage #(
   parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
   parameter int          IB_DEPTH        = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   input  logic [32:0] br_zip,
   output logic        fs2ds_valid,
   output logic [64:0] fs2ds_bus,
   input  logic        wb_ex,
   input  logic        ertn_flush,
   input  logic [31:0] ex_entry,
   input  logic [31:0] ertn_entry
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int PW = $clog2(IB_DEPTH);
   localparam logic [OW-1:0] MAX_OUT     = OW'(MAX_OUTSTANDING);
   localparam logic [PW:0]   IB_FULL_CNT = (PW+1)'(IB_DEPTH);
   localparam logic [TW-1:0] TAG_LAST    = TW'(MAX_OUTSTANDING - 1);
   localparam logic [31:0]   IB_DEPTH_W  = 32'(IB_DEPTH);

   logic          started;
   logic          req_hold;
   logic          doomed;
   logic          adef_done;
   logic [31:0]   pc;
   logic [31:0]   addr_q;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] discard;
   logic [OW-1:0] out_next;

   logic [31:0]   tag_mem [MAX_OUTSTANDING];
   logic [TW-1:0] tag_wr;
   logic [TW-1:0] tag_rd;

   logic [64:0]   ib_mem [IB_DEPTH];
   logic [PW:0]   ib_wr;
   logic [PW:0]   ib_rd;
   logic [PW:0]   ib_count;
   logic          ib_empty;
   logic          ib_full;

   logic          br_taken;
   logic [31:0]   br_target;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          can_issue;
   logic          acc;
   logic          resp_push;
   logic          adef_push;
   logic          ib_push;
   logic          ib_pop;
   logic [64:0]   push_data;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TAG_LAST) ? '0 : p + 1'b1;
   endfunction

   assign {br_taken, br_target} = br_zip;
   assign redirect    = wb_ex || ertn_flush || br_taken;
   assign redirect_pc = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);

   assign ib_count = ib_wr - ib_rd;
   assign ib_empty = (ib_count == '0);
   assign ib_full  = (ib_count == IB_FULL_CNT);

   // Credit counts every in-flight word, so a kept response always has a slot.
   assign can_issue = (outstanding < MAX_OUT)
                   && ((32'(ib_count) + 32'(outstanding)) < IB_DEPTH_W)
                   && (pc[1:0] == 2'b00);

   assign inst_sram_req   = started && (req_hold || can_issue);
   assign inst_sram_addr  = req_hold ? addr_q : pc;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;

   assign acc       = inst_sram_req && inst_sram_addr_ok;
   assign out_next  = outstanding + OW'(acc) - OW'(inst_sram_data_ok);
   assign resp_push = inst_sram_data_ok && (discard == '0) && !redirect;
   assign adef_push = (pc[1:0] != 2'b00) && !adef_done && (outstanding == '0)
                   && !ib_full && !redirect;
   assign ib_push   = resp_push || adef_push;
   assign push_data = adef_push ? {1'b1, 32'h0, pc}
                                : {1'b0, inst_sram_rdata, tag_mem[tag_rd]};

   assign fs2ds_valid = !ib_empty && !redirect;
   assign fs2ds_bus   = ib_mem[ib_rd[PW-1:0]];
   assign ib_pop      = fs2ds_valid && ds_allowin;

   // Fetch control: pc, held-request tracking, in-flight and drop counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         started     <= 1'b0;
         req_hold    <= 1'b0;
         doomed      <= 1'b0;
         adef_done   <= 1'b0;
         pc          <= RESET_PC;
         addr_q      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         started     <= 1'b1;
         req_hold    <= inst_sram_req && !inst_sram_addr_ok;
         outstanding <= out_next;
         if (inst_sram_req && !inst_sram_addr_ok)
            addr_q <= inst_sram_addr;
         if (acc)
            tag_wr <= tag_inc(tag_wr);
         if (inst_sram_data_ok)
            tag_rd <= tag_inc(tag_rd);
         if (redirect) begin
            pc        <= redirect_pc;
            discard   <= out_next;
            doomed    <= inst_sram_req && !inst_sram_addr_ok;
            adef_done <= 1'b0;
         end else begin
            if (acc && !doomed)
               pc <= pc + 32'd4;
            discard <= discard - OW'(inst_sram_data_ok && (discard != '0))
                               + OW'(acc && doomed);
            if (acc)
               doomed <= 1'b0;
            if (adef_push)
               adef_done <= 1'b1;
         end
      end
   end

   // Tag storage: pc of each accepted request, read back in order.
   always_ff @(posedge clk) begin
      if (acc)
         tag_mem[tag_wr] <= inst_sram_addr;
   end

   // Instruction buffer pointers; a redirect empties the buffer.
   always_ff @(posedge clk) begin
      if (!resetn || redirect) begin
         ib_wr <= '0;
         ib_rd <= '0;
      end else begin
         if (ib_push)
            ib_wr <= ib_wr + 1'b1;
         if (ib_pop)
            ib_rd <= ib_rd + 1'b1;
      end
   end

   // Instruction buffer storage.
   always_ff @(posedge clk) begin
      if (ib_push)
         ib_mem[ib_wr[PW-1:0]] <= push_data;
   end

endmodule

// File: tb/tb_fetch_ibuf_stage.sv
// Directed and randomised bench for fetch_ibuf_stage: an in-order bus
// responder returns addr ^ KEY for each accepted address, and a pc model
// predicts every word handed to decode, following redirects.
module tb_fetch_ibuf_stage;

   localparam logic [31:0] RESET_PC        = 32'h1C00_0000;
   localparam int          IB_DEPTH        = 4;
   localparam int          MAX_OUTSTANDING = 2;
   localparam logic [31:0] KEY             = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        ds_allowin;
   logic [32:0] br_zip;
   logic        fs2ds_valid;
   logic [64:0] fs2ds_bus;
   logic        wb_ex;
   logic        ertn_flush;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;

   always #5 clk = ~clk;

   fetch_ibuf_stage #(
      .RESET_PC(RESET_PC), .IB_DEPTH(IB_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin), .br_zip(br_zip),
      .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
      .wb_ex(wb_ex), .ertn_flush(ertn_flush), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
   );

   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } pend_t;

   pend_t       pending[$];
   int          nvec = 0;
   int          nfail = 0;
   int          cyc = 0;
   int          ao_mode = 1;
   int          lat_min = 0;
   int          lat_max = 0;
   logic [31:0] exp_pc;
   bit          exp_stalled;
   bit          prev_hold;
   logic [31:0] prev_addr;
   bit          mon_req, mon_acc, mon_hs, mon_valid;
   logic [31:0] mon_addr;
   logic [64:0] last_hs_bus;
   int          hs_count = 0;

   // One clock: observe at negedge, then drive the responder after posedge.
   task automatic step();
      logic        redir;
      logic [31:0] tgt;
      logic [64:0] exp_bus;
      pend_t       p;
      @(negedge clk);
      if (prev_hold) begin
         nvec++;
         if (inst_sram_req !== 1'b1 || inst_sram_addr !== prev_addr) begin
            nfail++;
            $display("FAIL held_req: req=%b addr=%h required req=1 addr=%h", inst_sram_req, inst_sram_addr, prev_addr);
         end
      end
      if (inst_sram_req === 1'b1) begin
         nvec++;
         if (inst_sram_addr[1:0] !== 2'b00) begin
            nfail++;
            $display("FAIL req_align: addr=%h required word aligned", inst_sram_addr);
         end
      end
      mon_req   = (inst_sram_req === 1'b1);
      mon_addr  = inst_sram_addr;
      mon_acc   = mon_req && inst_sram_addr_ok;
      mon_valid = (fs2ds_valid === 1'b1);
      if (mon_acc) begin
         p.addr = inst_sram_addr;
         p.rdy  = cyc + 1 + $urandom_range(lat_min, lat_max);
         pending.push_back(p);
      end
      if (inst_sram_data_ok)
         void'(pending.pop_front());
      redir = wb_ex || ertn_flush || br_zip[32];
      tgt   = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_zip[31:0]);
      if (redir) begin
         nvec++;
         if (fs2ds_valid !== 1'b0) begin
            nfail++;
            $display("FAIL valid_on_redirect: fs2ds_valid=%b required 0", fs2ds_valid);
         end
      end
      mon_hs = mon_valid && ds_allowin;
      if (mon_hs) begin
         hs_count++;
         last_hs_bus = fs2ds_bus;
         exp_bus = (exp_pc[1:0] != 2'b00) ? {1'b1, 32'h0, exp_pc} : {1'b0, exp_pc ^ KEY, exp_pc};
         nvec++;
         if (exp_stalled) begin
            nfail++;
            $display("FAIL push_after_adef: bus=%h required no delivery", fs2ds_bus);
         end else if (fs2ds_bus !== exp_bus) begin
            nfail++;
            $display("FAIL fs2ds_bus: got %h required %h", fs2ds_bus, exp_bus);
         end
         if (exp_pc[1:0] != 2'b00) exp_stalled = 1'b1;
         else exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
         exp_pc      = tgt;
         exp_stalled = 1'b0;
      end
      prev_hold = mon_req && !inst_sram_addr_ok;
      prev_addr = inst_sram_addr;
      @(posedge clk);
      #1;
      cyc++;
      case (ao_mode)
         0:       inst_sram_addr_ok = 1'b0;
         1:       inst_sram_addr_ok = 1'b1;
         default: inst_sram_addr_ok = ($urandom_range(0, 1) == 1);
      endcase
      if (pending.size() > 0 && pending[0].rdy <= cyc) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = pending[0].addr ^ KEY;
      end else begin
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = $urandom;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
      ds_allowin = 1'b1; br_zip = '0; wb_ex = 1'b0; ertn_flush = 1'b0; ex_entry = '0; ertn_entry = '0;
      pending.delete(); exp_pc = RESET_PC; exp_stalled = 1'b0; prev_hold = 1'b0;
      ao_mode = 1; lat_min = 0; lat_max = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      nvec++;
      if (inst_sram_req !== 1'b0 || fs2ds_valid !== 1'b0) begin
         nfail++;
         $display("FAIL reset_outputs: req=%b valid=%b required 0 0", inst_sram_req, fs2ds_valid);
      end
      nvec++;
      if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
         nfail++;
         $display("FAIL bus_constants: wr=%b size=%b wstrb=%h wdata=%h required 0 10 0 0",
                  inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      nvec++;
      if (inst_sram_req !== 1'b0) begin
         nfail++;
         $display("FAIL req_before_start: req=%b required 0", inst_sram_req);
      end
      @(posedge clk);
      #1;
      inst_sram_addr_ok = 1'b1;
      step();
      nvec++;
      if (!mon_acc || mon_addr !== RESET_PC) begin
         nfail++;
         $display("FAIL first_req: acc=%b addr=%h required 1 %h", mon_acc, mon_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_acc;
      bit          got;
      ds_allowin = 1'b1; ao_mode = 1; lat_min = 0; lat_max = 0;
      exp_acc = RESET_PC + 32'd4;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (mon_acc) begin
            nvec++;
            if (mon_addr !== exp_acc) begin
               nfail++;
               $display("FAIL seq_addr: got %h required %h", mon_addr, exp_acc);
            end
            exp_acc = exp_acc + 32'd4;
         end
         if (mon_hs) got = 1'b1;
      end
      nvec++;
      if (!got) begin
         nfail++;
         $display("FAIL first_fetch: no delivery within 8 cycles, required one");
      end
      for (int i = 0; i < 10; i++) begin
         step();
         if (mon_acc) begin
            nvec++;
            if (mon_addr !== exp_acc) begin
               nfail++;
               $display("FAIL seq_addr: got %h required %h", mon_addr, exp_acc);
            end
            exp_acc = exp_acc + 32'd4;
         end
         nvec++;
         if (!mon_hs) begin
            nfail++;
            $display("FAIL one_per_cycle: cycle %0d had no delivery, required one", i);
         end
      end
   endtask

   task automatic test_stall();
      int h0;
      ds_allowin = 1'b0;
      repeat (10) step();
      nvec++;
      if (mon_req || !mon_valid || pending.size() != 0) begin
         nfail++;
         $display("FAIL stall_full: req=%b valid=%b inflight=%0d required 0 1 0", mon_req, mon_valid, pending.size());
      end
      ao_mode = 0; inst_sram_addr_ok = 1'b0; ds_allowin = 1'b1;
      h0 = hs_count;
      repeat (8) step();
      nvec++;
      if (hs_count - h0 != IB_DEPTH) begin
         nfail++;
         $display("FAIL ib_entries: drained %0d required %0d", hs_count - h0, IB_DEPTH);
      end
      nvec++;
      if (!mon_req || mon_valid) begin
         nfail++;
         $display("FAIL after_drain: req=%b valid=%b required 1 0", mon_req, mon_valid);
      end
      ao_mode = 1; inst_sram_addr_ok = 1'b1;
   endtask

   task automatic test_wb_ex();
      bit got;
      lat_min = 4; lat_max = 4; ds_allowin = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (pending.size() == 2) got = 1'b1;
      end
      nvec++;
      if (!got) begin
         nfail++;
         $display("FAIL two_outstanding: inflight=%0d required 2", pending.size());
      end
      wb_ex = 1'b1; ex_entry = 32'h1C00_8000;
      step();
      wb_ex = 1'b0;
      lat_min = 0; lat_max = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (mon_hs) got = 1'b1;
      end
      nvec++;
      if (!got || last_hs_bus[31:0] !== 32'h1C00_8000) begin
         nfail++;
         $display("FAIL wbex_target: delivered=%b pc=%h required 1 1c008000", got, last_hs_bus[31:0]);
      end
   endtask

   task automatic test_br_held();
      logic [31:0] held;
      bit          got;
      ao_mode = 0; inst_sram_addr_ok = 1'b0; ds_allowin = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (mon_req) got = 1'b1;
      end
      held = mon_addr;
      nvec++;
      if (!got) begin
         nfail++;
         $display("FAIL held_setup: req=%b required 1", mon_req);
      end
      br_zip = {1'b1, 32'h1C00_0100};
      step();
      br_zip = '0;
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (!mon_req || mon_addr !== held) begin
            nfail++;
            $display("FAIL doomed_stable: req=%b addr=%h required 1 %h", mon_req, mon_addr, held);
         end
         if (i < 2) step();
      end
      ao_mode = 1; inst_sram_addr_ok = 1'b1;
      step();
      nvec++;
      if (!mon_acc || mon_addr !== held) begin
         nfail++;
         $display("FAIL doomed_accept: acc=%b addr=%h required 1 %h", mon_acc, mon_addr, held);
      end
      step();
      nvec++;
      if (!mon_acc || mon_addr !== 32'h1C00_0100) begin
         nfail++;
         $display("FAIL br_target_req: acc=%b addr=%h required 1 1c000100", mon_acc, mon_addr);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (mon_hs) got = 1'b1;
      end
      nvec++;
      if (!got || last_hs_bus[31:0] !== 32'h1C00_0100) begin
         nfail++;
         $display("FAIL br_target_pc: delivered=%b pc=%h required 1 1c000100", got, last_hs_bus[31:0]);
      end
   endtask

   task automatic test_adef();
      int h0;
      bit got;
      lat_min = 0; lat_max = 2; ao_mode = 1; ds_allowin = 1'b1;
      ertn_flush = 1'b1; ertn_entry = 32'h1C00_0002;
      step();
      ertn_flush = 1'b0;
      h0 = hs_count;
      repeat (12) step();
      nvec++;
      if (hs_count - h0 != 1) begin
         nfail++;
         $display("FAIL adef_count: delivered %0d required 1", hs_count - h0);
      end
      nvec++;
      if (last_hs_bus !== {1'b1, 32'h0, 32'h1C00_0002}) begin
         nfail++;
         $display("FAIL adef_bus: got %h required %h", last_hs_bus, {1'b1, 32'h0, 32'h1C00_0002});
      end
      nvec++;
      if (mon_req || mon_valid) begin
         nfail++;
         $display("FAIL adef_stall: req=%b valid=%b required 0 0", mon_req, mon_valid);
      end
      br_zip = {1'b1, 32'h1C00_0200};
      step();
      br_zip = '0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (mon_hs) got = 1'b1;
      end
      nvec++;
      if (!got || last_hs_bus[31:0] !== 32'h1C00_0200) begin
         nfail++;
         $display("FAIL adef_recover: delivered=%b pc=%h required 1 1c000200", got, last_hs_bus[31:0]);
      end
      lat_min = 0; lat_max = 0;
   endtask

   task automatic test_random();
      int       h0;
      logic [2:0] r;
      lat_min = 0; lat_max = 5; ao_mode = 2;
      h0 = hs_count;
      for (int i = 0; i < 400; i++) begin
         ds_allowin = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            r          = 3'($urandom_range(1, 7));
            wb_ex      = r[0];
            ertn_flush = r[1];
            ex_entry   = 32'h1C00_4000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            ertn_entry = 32'h1C00_6000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            br_zip     = {r[2], 32'h1C00_2000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00}};
         end
         step();
         wb_ex = 1'b0; ertn_flush = 1'b0; br_zip = '0;
      end
      nvec++;
      if (hs_count - h0 < 30) begin
         nfail++;
         $display("FAIL random_progress: delivered %0d required at least 30", hs_count - h0);
      end
      ao_mode = 1; lat_min = 0; lat_max = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_wb_ex();
      test_br_held();
      test_adef();
      test_random();
      test_reset();
      test_sequential();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
